mem_access_sched: RTL
=====================

MEM_ACCESS_SCHED -- requirements
Module: mem_access_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk_i and rst_i.
REQ-002 Parameter NUM_REQ, default 2, SHALL set the number of requesters and SHALL always be a power of 2.
REQ-003 Parameter ADDR_W, default 32, SHALL set the address width; DATA_W, default 32, SHALL set the data width.
REQ-004 Parameter WEIGHT_W, default 3, SHALL set the weight width; WEIGHTS, default {3'd1,3'd1}, SHALL hold requester i's weight at [i*WEIGHT_W +: WEIGHT_W].
REQ-005 Parameter TIMEOUT_CYCLES, default 255, SHALL set the ack timeout in cycles, with a range of 1..255.
REQ-006 The ports SHALL be, one per line (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept strobe
- req_we_i  in  NUM_REQ  per-requester write enable
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata_i  in  NUM_REQ*DATA_W  packed write data; same packing as req_addr_i
- rsp_valid_o  out  NUM_REQ  one-hot response strobe
- rsp_rdata_o  out  DATA_W  response read data, shared by all requesters
- rsp_err_o  out  1  response error flag
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory acknowledge
- mem_rdata_i  in  DATA_W  memory read data
- busy_o  out  1  high when the FSM is not in IDLE

Function
REQ-007 The FSM SHALL have three states, IDLE, ISSUE and RESP, with one transaction in flight at a time.
REQ-008 In IDLE with any req_valid_i bit set, the arbiter SHALL pick winner w:
- w = ptr if req_valid_i[ptr] is set;
- otherwise w = the first valid index in ptr+1, ptr+2, ..., searching modulo NUM_REQ.
REQ-009 Weight/credit update on a grant SHALL be as follows, with a weight of 0 treated as 1:
- if w==ptr and credit>1: credit <= credit-1;
- if w!=ptr and weight[w]>1: ptr <= w and credit <= weight[w]-1;
- otherwise: ptr <= (w+1) mod NUM_REQ and credit <= weight[ptr_new].
REQ-010 In the grant cycle, req_ready_o[w] SHALL be 1 (combinational, one-hot); req_we/addr/wdata of w and the index w SHALL be registered, and the FSM SHALL go to ISSUE.
REQ-011 req_ready_o SHALL be all zeros outside IDLE and when no request is valid; the ptr/credit state SHALL be unchanged when no grant occurs.
REQ-012 In ISSUE, mem_req_o SHALL be 1, and mem_we_o, mem_addr_o and mem_wdata_o SHALL be held stable from the registered values until mem_ack_i is sampled 1.
REQ-013 On mem_ack_i=1 in ISSUE, the block SHALL capture rdata as mem_rdata_i for a read or 0 for a write, and the FSM SHALL go to RESP.
REQ-014 In RESP, rsp_valid_o[w] SHALL be 1 for exactly one cycle with rsp_rdata_o set to the captured data, and the FSM SHALL then return to IDLE.
REQ-015 Minimum latency SHALL be: accept at cycle T, mem_req_o high at T+1, ack at T+1, rsp_valid_o at T+2, next accept at T+3.
REQ-016 mem_ack_i SHALL be ignored outside ISSUE.
REQ-017 rsp_rdata_o SHALL hold its last value outside RESP; mem_req_o SHALL be 0 outside ISSUE.
REQ-018 busy_o SHALL be 1 whenever state != IDLE.

Reset
REQ-019 On rst_i the block SHALL set: state=IDLE, ptr=0, credit=weight[0] (0 treated as 1), and all outputs 0.
REQ-020 A reset mid-transaction SHALL discard the in-flight request without issuing a response, and mem_req_o SHALL be 0 in the following cycle.

Configuration
REQ-021 Macro MEM_ACCESS_SCHED_TIMEOUT_EN defined: a counter SHALL clear on entry to ISSUE and count each ISSUE cycle without ack; after TIMEOUT_CYCLES such cycles, the FSM SHALL go to RESP with rsp_err_o=1 and rsp_rdata_o=0.
REQ-022 With the timeout macro defined, an ack arriving in the same cycle the count expires SHALL win (err=0), and rsp_err_o SHALL be 1 only during that RESP cycle.
REQ-023 Macro MEM_ACCESS_SCHED_TIMEOUT_EN undefined: ISSUE SHALL wait indefinitely, rsp_err_o SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-024 WEIGHTS={3'd1,3'd3}, both requesters always valid, ack immediate -> grant order SHALL be 0,0,0,1,0,0,0,1.
REQ-025 Only req 1 valid, reads at addr 0x40, mem_rdata_i=0xDEADBEEF, ack immediate -> rsp_valid_o=2'b10 at T+2 with rsp_rdata_o=0xDEADBEEF.
REQ-026 Write at addr 0x10 with wdata 0x1234, ack delayed 5 cycles -> mem_req_o high for 6 cycles with mem_addr_o=0x10 stable, then rsp_rdata_o=0.
REQ-027 rst_i asserted during ISSUE -> next cycle mem_req_o=0, busy_o=0, and no rsp_valid_o is produced.
REQ-028 MEM_ACCESS_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> rsp_err_o=1 and rsp_rdata_o=0 after 4 ISSUE cycles; a late ack afterwards is ignored.
REQ-029 Only req 1 valid while ptr=0 with default weights -> req 1 SHALL be granted without an idle cycle, and afterwards ptr=0.

Source files
------------

// File: rtl/mem_access_sched.sv
// Weighted round-robin scheduler with one memory access in flight; define MEM_ACCESS_SCHED_TIMEOUT_EN for ack timeout.
// Latency: accept T, mem_req T+1, rsp T+2 at best; requesters wait (ready low) while a transaction is in flight.
module mem_access_sched #(
   parameter int                          NUM_REQ        = 2,
   parameter int                          ADDR_W         = 32,
   parameter int                          DATA_W         = 32,
   parameter int                          WEIGHT_W       = 3,
   parameter logic [NUM_REQ*WEIGHT_W-1:0] WEIGHTS        = {3'd1, 3'd1},
   parameter int                          TIMEOUT_CYCLES = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ-1:0]        req_we_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic [DATA_W-1:0]         mem_wdata_o,
   input  logic                      mem_ack_i,
   input  logic [DATA_W-1:0]         mem_rdata_i,
   output logic                      busy_o
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t              state_q, state_n;
   logic [PW-1:0]       ptr_q, ptr_n, win, win_q, idx;
   logic [WEIGHT_W-1:0] credit_q, credit_n;
   logic                found, grant, tmo;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end

   // A zero weight behaves as weight 1 so a requester can never be starved.
   function automatic logic [WEIGHT_W-1:0] eff_w(input logic [PW-1:0] i);
      logic [WEIGHT_W-1:0] w;
      w = WEIGHTS[int'(i)*WEIGHT_W +: WEIGHT_W];
      return (w == '0) ? WEIGHT_W'(1) : w;
   endfunction

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = PW'((int'(ptr_q) + i) % NUM_REQ);
         if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign grant = found && (state_q == IDLE) && !rst_i;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = grant && (win == PW'(i));
         rsp_valid_o[i] = (state_q == RESP) && (win_q == PW'(i));
      end
   end

   always_comb begin
      ptr_n    = ptr_q;
      credit_n = credit_q;
      if (grant) begin
         if (win == ptr_q && credit_q > WEIGHT_W'(1)) begin
            credit_n = credit_q - WEIGHT_W'(1);
         end else if (win != ptr_q && eff_w(win) > WEIGHT_W'(1)) begin
            ptr_n    = win;
            credit_n = eff_w(win) - WEIGHT_W'(1);
         end else begin
            ptr_n    = PW'((int'(win) + 1) % NUM_REQ);
            credit_n = eff_w(ptr_n);
         end
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (grant) state_n = ISSUE;
         ISSUE:   if (mem_ack_i || tmo) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_n;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q    <= '0;
         credit_q <= eff_w('0);
         win_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         ptr_q    <= ptr_n;
         credit_q <= credit_n;
         if (grant) begin
            win_q   <= win;
            we_q    <= req_we_i[win];
            addr_q  <= req_addr_i[int'(win)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata_i[int'(win)*DATA_W +: DATA_W];
         end
         // An ack takes priority over an expiring timeout.
         if (state_q == ISSUE && mem_ack_i) rdata_q <= we_q ? '0 : mem_rdata_i;
         else if (tmo)                     rdata_q <= '0;
      end
   end

`ifdef MEM_ACCESS_SCHED_TIMEOUT_EN
   logic [7:0] cnt_q;
   logic       err_q;

   assign tmo = (state_q == ISSUE) && !mem_ack_i && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || state_q != ISSUE) cnt_q <= '0;
      else if (!mem_ack_i)           cnt_q <= cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)                              err_q <= 1'b0;
      else if (state_q == ISSUE && mem_ack_i) err_q <= 1'b0;
      else if (tmo)                           err_q <= 1'b1;
   end

   assign rsp_err_o = (state_q == RESP) && err_q;
`else
   assign tmo       = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   assign mem_req_o   = (state_q == ISSUE);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rsp_rdata_o = rdata_q;
   assign busy_o      = (state_q != IDLE);

endmodule
